// File: rtl/ctrl_spi_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_spi_pkg
// Shared types and helpers for the theremin control-frame SPI master.
//   state_t   : frame sequencer states
//   CH_*      : channel index of each control value within the frame
//   half_cyc  : clk cycles per SCLK half period, never below one
// ---------------------------------------------------------------------------
package ctrl_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    localparam int unsigned CH_A16    = 0;
    localparam int unsigned CH_A8     = 1;
    localparam int unsigned CH_A5     = 2;
    localparam int unsigned CH_A4     = 3;
    localparam int unsigned CH_BLEND  = 4;
    localparam int unsigned CH_DELAY  = 5;
    localparam int unsigned CH_FEEDBK = 6;
    localparam int unsigned CH_GAIN   = 7;

    // Integer floor of f_clk/(2*f_sclk), clamped to at least one cycle.
    function automatic int unsigned half_cyc(input int unsigned f_clk,
                                             input int unsigned f_sclk);
        int unsigned h;
        h = f_clk / (2 * f_sclk);
        return (h == 0) ? 1 : h;
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// ---------------------------------------------------------------------------
// spi_half_tick
// Reloadable half-period counter: pulses o_tick_c on the HALF-th enabled
// cycle, then restarts. Cleared whenever the sequencer changes state.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_en         : count enable
//   i_clr        : restart count from zero
//   o_tick_c     : combinational tick, high on the last cycle of a half period
// ---------------------------------------------------------------------------
module spi_half_tick #(
    parameter int unsigned HALF = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned W_CNT = (HALF > 1) ? $clog2(HALF + 1) : 1;

    logic [W_CNT-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == W_CNT'(HALF - 1));

    // Wrap on tick so consecutive half periods in one state stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick_c || !i_en) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W_CNT'(1);
        end
    end

endmodule

// File: rtl/ctrl_spi_master.sv
// ---------------------------------------------------------------------------
// ctrl_spi_master
// SPI mode-0 master that latches the eight control channels on go and sends
// them as one SS_n-framed burst, channel 0 first, MSB first, followed by an
// inter-frame gap.
// Build option: define CTRL_SPI_CHECKSUM_EN to append an XOR-of-all-channels
// byte after the last channel (receiver must match).
//   clk, reset_n : clock, asynchronous active-low reset
//   in           : channel i at in[i*BITS +: BITS]
//   go           : frame request, ignored while busy
//   busy         : frame or gap in progress
//   done         : one-cycle pulse as SS_n rises
//   SCLK/MOSI/SS_n : SPI pins, all registered
// ---------------------------------------------------------------------------
module ctrl_spi_master
    import ctrl_spi_pkg::*;
#(
    parameter int unsigned BITS  = 8,
    parameter int unsigned N_CH  = 8,
    parameter int unsigned fCLK  = 50_000_000,
    parameter int unsigned fSCLK = 1_000_000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_CH*BITS-1:0] in,
    input  logic                 go,
    output logic                 busy,
    output logic                 done,
    output logic                 SCLK,
    output logic                 MOSI,
    output logic                 SS_n
);

    localparam int unsigned HALF = half_cyc(fCLK, fSCLK);
`ifdef CTRL_SPI_CHECKSUM_EN
    localparam int unsigned N_TOT = (N_CH + 1) * BITS;
`else
    localparam int unsigned N_TOT = N_CH * BITS;
`endif
    localparam int unsigned W_BIT = $clog2(N_TOT + 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_tick;
    logic               w_load;
    logic               w_shift;
    logic [N_TOT-1:0]   w_frame;
    logic [N_TOT-1:0]   r_shift;
    logic [W_BIT-1:0]   r_bits;
    logic               r_gap2;
    logic               r_sclk;
    logic               r_ss_n;
    logic               r_busy;
    logic               r_done;

    spi_half_tick #(
        .HALF (HALF)
    ) u_half_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_en     (r_state != IDLE),
        .i_clr    (w_next != r_state),
        .o_tick_c (w_tick)
    );

    // Frame image: channel 0 in the top bits so the MSB of the vector leaves first.
`ifdef CTRL_SPI_CHECKSUM_EN
    logic [BITS-1:0] w_csum;
    always_comb begin
        w_frame = '0;
        w_csum  = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_frame[N_TOT-1-i*BITS -: BITS] = in[i*BITS +: BITS];
            w_csum = w_csum ^ in[i*BITS +: BITS];
        end
        w_frame[BITS-1:0] = w_csum;
    end
`else
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            w_frame[N_TOT-1-i*BITS -: BITS] = in[i*BITS +: BITS];
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_next = SETUP;
                    w_load = 1'b1;
                end
            end
            SETUP: if (w_tick) w_next = LOW;
            LOW:   if (w_tick) w_next = HIGH;
            HIGH: begin
                if (w_tick) begin
                    if (r_bits == W_BIT'(N_TOT - 1)) begin
                        w_next = HOLD;
                    end else begin
                        w_next  = LOW;
                        w_shift = 1'b1;
                    end
                end
            end
            HOLD:  if (w_tick) w_next = GAP;
            GAP:   if (w_tick && r_gap2) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Shift register, counters and pins; pins are decoded from the next state
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_bits  <= '0;
            r_gap2  <= 1'b0;
            r_sclk  <= 1'b0;
            r_ss_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift <= w_frame;
                r_bits  <= '0;
            end else if (w_shift) begin
                r_shift <= {r_shift[N_TOT-2:0], 1'b0};
                r_bits  <= r_bits + W_BIT'(1);
            end
            // The gap spans two half periods.
            if (r_state != GAP) begin
                r_gap2 <= 1'b0;
            end else if (w_tick) begin
                r_gap2 <= 1'b1;
            end
            r_sclk <= (w_next == HIGH);
            r_ss_n <= (w_next == IDLE) || (w_next == GAP);
            r_busy <= (w_next != IDLE);
            r_done <= (r_state == HOLD) && (w_next == GAP);
        end
    end

    assign SCLK = r_sclk;
    assign MOSI = r_shift[N_TOT-1];
    assign SS_n = r_ss_n;
    assign busy = r_busy;
    assign done = r_done;

endmodule
